// File: rtl/dvp_pkg.sv
// dvp_pkg: state encoding and byte-order constants shared by the DVP transmitter
// and the pixel_reconstruct benches.
package dvp_pkg;
    typedef enum logic [2:0] {IDLE, VSYNC, VBACK, LINE_ACTIVE, LINE_BLANK, VFRONT} dvp_state_t;
    localparam bit HI_FIRST = 1'b1;
endpackage

// File: rtl/pclk_divider.sv
// pclk_divider: divides clk_in into pclk and flags the clk_in cycle before each
// pclk edge, so the caller can update outputs in step with pclk falling.
module pclk_divider #(
    parameter int PCLK_HALF = 2
) (
    input  logic clk_in,
    input  logic rst_in,
    output logic pclk_out,
    output logic fall_tick_out,
    output logic rise_tick_out
);
    localparam int CW = PCLK_HALF > 1 ? $clog2(PCLK_HALF) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic pclk_q, pclk_d, tc;
    always_comb begin
        tc = cnt_q == CW'(PCLK_HALF - 1);
        cnt_d = tc ? '0 : cnt_q + 1'b1;
        pclk_d = pclk_q ^ tc;
    end
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q <= '0;
            pclk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pclk_q <= pclk_d;
        end
    end
    assign pclk_out = pclk_q;
    assign fall_tick_out = tc & pclk_q;
    assign rise_tick_out = tc & ~pclk_q;
endmodule

// File: rtl/dvp_camera_tx.sv
// dvp_camera_tx: RGB565 valid/ready source to 8-bit DVP bus with OV5640-style
// frame timing; everything updates on pclk fall ticks.
module dvp_camera_tx
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE    = 1280,
    parameter int H_BLANK     = 64,
    parameter int V_ACTIVE    = 720,
    parameter int VSYNC_LINES = 4,
    parameter int V_BACK      = 8,
    parameter int V_FRONT     = 4,
    parameter int PCLK_HALF   = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        enable_in,
    input  logic [15:0] pixel_data_in,
    input  logic        pixel_valid_in,
    output logic        pixel_ready_out,
    output logic        pclk_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic [7:0]  data_out,
    output logic        frame_start_out,
    output logic        underflow_out
);
    localparam int L = 2 * H_ACTIVE + H_BLANK;
    localparam int SW = $clog2(L);
    localparam int M1 = VSYNC_LINES > V_BACK ? VSYNC_LINES : V_BACK;
    localparam int M2 = V_ACTIVE > V_FRONT ? V_ACTIVE : V_FRONT;
    localparam int LMAX = M1 > M2 ? M1 : M2;
    localparam int LW = LMAX > 1 ? $clog2(LMAX) : 1;

    dvp_state_t state_q, state_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [LW-1:0] line_q, line_d, line_end;
    logic [7:0] data_q, data_d, hold_q, hold_d, hi, lo;
    logic under_q, under_d, fs_q, fs_d;
    logic fall_tick, slot_last, act_last, line_last, ready;

    pclk_divider #(.PCLK_HALF(PCLK_HALF)) u_div (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .pclk_out      (pclk_out),
        .fall_tick_out (fall_tick),
        .rise_tick_out ()
    );

    always_comb begin
        slot_last = slot_q == SW'(L - 1);
        act_last = slot_q == SW'(2 * H_ACTIVE - 1);
        line_end = state_q == VSYNC ? LW'(VSYNC_LINES - 1) : state_q == VBACK ? LW'(V_BACK - 1) :
                   state_q == VFRONT ? LW'(V_FRONT - 1) : LW'(V_ACTIVE - 1);
        line_last = line_q == line_end;
        state_d = state_q;
        slot_d = slot_q;
        line_d = line_q;
        if (fall_tick) begin
            slot_d = (state_q == IDLE || slot_last) ? '0 : slot_q + 1'b1;
            line_d = !slot_last ? line_q : line_last ? '0 : line_q + 1'b1;
            case (state_q)
                IDLE:        if (enable_in) state_d = VSYNC;
                VSYNC:       if (slot_last && line_last) state_d = VBACK;
                VBACK:       if (slot_last && line_last) state_d = LINE_ACTIVE;
                LINE_ACTIVE: if (act_last) state_d = LINE_BLANK;
                LINE_BLANK:  if (slot_last) state_d = line_last ? VFRONT : LINE_ACTIVE;
                VFRONT:      if (slot_last && line_last) state_d = enable_in ? VSYNC : IDLE;
                default:     state_d = IDLE;
            endcase
        end
    end

    // Ready marks the fall tick that begins an even active slot; built from state only.
    assign ready = fall_tick && ((state_q == LINE_ACTIVE && slot_q[0] && !act_last) ||
                                 (state_q == VBACK && slot_last && line_last) ||
                                 (state_q == LINE_BLANK && slot_last && !line_last));

    always_comb begin
        hi = HI_FIRST ? pixel_data_in[15:8] : pixel_data_in[7:0];
        lo = HI_FIRST ? pixel_data_in[7:0] : pixel_data_in[15:8];
        data_d = data_q;
        if (fall_tick)
            data_d = ready ? (pixel_valid_in ? hi : 8'h00) :
                     (state_q == LINE_ACTIVE && !slot_q[0]) ? hold_q : 8'h00;
        hold_d = ready ? (pixel_valid_in ? lo : 8'h00) : hold_q;
        under_d = under_q | (ready & ~pixel_valid_in);
        fs_d = fall_tick && state_q != VSYNC && state_d == VSYNC;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            slot_q <= '0;
            line_q <= '0;
            data_q <= '0;
            hold_q <= '0;
            under_q <= 1'b0;
            fs_q <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q <= slot_d;
            line_q <= line_d;
            data_q <= data_d;
            hold_q <= hold_d;
            under_q <= under_d;
            fs_q <= fs_d;
        end
    end

    assign pixel_ready_out = ready;
    assign hsync_out = state_q == LINE_ACTIVE;
    assign vsync_out = state_q == VSYNC;
    assign data_out = data_q;
    assign frame_start_out = fs_q;
    assign underflow_out = under_q;
endmodule
